as2650_gpio_ports: RTL and testbench
====================================

# as2650_gpio_ports

Parametrised GPIO port bank for the AS2650 extended I/O space. It provides NPORTS ports of WIDTH bits each, with per-bit direction, two-flop input synchronisers, and per-bit pin-change interrupt flags. It sits between the CPU's extended I/O bus (the WRTE/REDE address/data strobes) and the user-project GPIO pads, and generalises the fixed PORTA-out/PORTB-in arrangement to any port count and per-bit direction.

## Interface

- NPORTS, 2: number of ports, 1..8.
- WIDTH, 8: bits per port, 1..8; unused read bits return 0.
- BASE_ADDR, 8'h00: first I/O address; bank occupies BASE_ADDR .. BASE_ADDR+4*NPORTS-1.
- IRQ_EDGE, 0: pin-change mode. 0 = any edge, 1 = rising, 2 = falling.

- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- io_addr  in  8  I/O address
- io_wdata  in  8  write data
- io_we  in  1  write strobe, one cycle per access
- io_re  in  1  read strobe, one cycle per access
- io_rdata  out  8  registered read data
- io_rvalid  out  1  one-cycle pulse: io_rdata is valid
- pins_in  in  NPORTS*WIDTH  raw pad inputs, asynchronous
- pins_out  out  NPORTS*WIDTH  pad output values
- pins_oe  out  NPORTS*WIDTH  pad output enables, 1 = drive
- irq  out  1  registered interrupt request, active high

## Operation

- Register map per port p, at offset BASE_ADDR+4p+r:
  - r0 DATA: write sets the output latch. Read returns (DDR & latch) | (~DDR & synced pin).
  - r1 DDR: 1 = output. pins_oe equals DDR.
  - r2 IMASK: 1 = the flag contributes to irq.
  - r3 IFLAG: read returns the flags. Writing 1 clears a bit; writing 0 leaves it unchanged.
- Port p maps to bits [p*WIDTH +: WIDTH] of the pin vectors.
- Input path: two-flop synchroniser, then a prev register for edge detection. Edges are detected on bits in either direction, so an output drive looped back through the pad still flags.
- Flag set condition per bit:
  - IRQ_EDGE 0: s2 != prev
  - IRQ_EDGE 1: s2 & ~prev
  - IRQ_EDGE 2: ~s2 & prev
- Flags are sticky until cleared.
- irq is registered as the OR over all ports of (IFLAG & IMASK).
- Write/read behaviour:
  - Writes to addresses outside the bank are ignored.
  - Reads outside the bank: io_rvalid stays low and io_rdata holds its previous value.
  - io_we and io_re asserted together: the write is performed and the read is ignored.
- Arming: edge detection is suppressed for the first 3 clk edges after rst_n deasserts, while the sync/prev pipeline fills. A pin held high through reset therefore raises no flag.
- Reset values (asynchronous): pins_out 0, pins_oe 0 (all inputs), IMASK 0, IFLAG 0, sync and prev registers 0, arm counter 0, irq 0, io_rdata 0, io_rvalid 0.
- Reset asserted mid-access: the access is dropped; no partial register update.

## Timing

- Write: a register updates at the clk edge that samples io_we. pins_out and pins_oe change at that edge.
- Read: io_rdata and io_rvalid are valid one cycle after the edge that samples io_re. io_rvalid is high for exactly one cycle.
- Pin to flag: a pin change sampled at edge k sets the flag at edge k+2. irq rises at edge k+3 if the bit is masked in.
- Set versus clear in the same cycle: set wins and the flag stays 1.
- DATA read of an input reflects the pin as sampled two edges earlier.
- IMASK write: takes effect on irq one edge later. Clearing the last pending masked flag drops irq one edge after the write edge.
- Back-to-back accesses are permitted on every cycle; there are no stall states.

## Configuration

- GPIO_IRQ_EN defined: IMASK, IFLAG, the prev registers, the arm counter and irq are built as described.
- GPIO_IRQ_EN undefined:
  - The interrupt logic is removed and irq is tied to 0.
  - r2 and r3 read as 0 and writes to them are ignored.
  - The synchronisers and DATA/DDR behave identically.

## Test plan

- Reset: hold rst_n low with pins_in all 1s, then release. Required: pins_out=0, pins_oe=0, irq=0. No flags after 10 cycles. Reading r3 of port 0 returns 8'h00 with io_rvalid one cycle after io_re.
- Direction/data (NPORTS=2, WIDTH=8): write DDR0=8'hF0, DATA0=8'h55, then drive pins_in[7:0]=8'hA3. Required: pins_oe[7:0]=8'hF0, pins_out[7:0]=8'h55. After 2 cycles, reading DATA0 returns 8'h53.
- Interrupt path: IMASK1=8'h01 with IRQ_EDGE=1, then pulse pin 8 high. Required: IFLAG1=8'h01 at k+2, irq=1 at k+3. Write r3=8'h01: irq falls one edge after the write edge.
- Set/clear collision: time the W1C of IFLAG1 bit 0 on the same edge as a new rising edge on that bit. Required: the flag reads 1 and irq stays high.
- Decode: write 8'hFF to BASE_ADDR+4*NPORTS and read it back. Required: no register changes and io_rvalid stays 0. Simultaneous io_we/io_re to DATA0 updates the latch and gives no io_rvalid.
- Macro off: with GPIO_IRQ_EN undefined, toggle every pin. Required: irq=0 throughout, and r2/r3 read 8'h00.

Source files
------------

// File: rtl/as2650_gpio_ports.sv
// GPIO port bank for the AS2650 extended I/O space: NPORTS x WIDTH pins with per-bit direction,
// two-flop input synchronisers and, when GPIO_IRQ_EN is defined, sticky pin-change flags and irq.
module as2650_gpio_ports #(
  parameter int          NPORTS    = 2,
  parameter int          WIDTH     = 8,
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter int          IRQ_EDGE  = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                io_addr,
  input  logic [7:0]                io_wdata,
  input  logic                      io_we,
  input  logic                      io_re,
  output logic [7:0]                io_rdata,
  output logic                      io_rvalid,
  input  logic [NPORTS*WIDTH-1:0]   pins_in,
  output logic [NPORTS*WIDTH-1:0]   pins_out,
  output logic [NPORTS*WIDTH-1:0]   pins_oe,
  output logic                      irq
);

  localparam int NB   = NPORTS * WIDTH;
  localparam int SPAN = 4 * NPORTS;

  // Bus protocol: io_we / io_re are single-cycle strobes sampled on clk; a write wins over a
  // simultaneous read, and an in-bank read answers with io_rvalid for exactly one cycle.
  logic [8:0] off9;
  logic       in_bank;
  logic [2:0] port_idx;
  logic [1:0] reg_idx;
  logic       wr;
  logic       rd;

  // Addresses below BASE_ADDR wrap to bit 8 set and so fall outside the span.
  assign off9     = {1'b0, io_addr} - {1'b0, BASE_ADDR};
  assign in_bank  = (off9 < 9'(SPAN));
  assign port_idx = off9[4:2];
  assign reg_idx  = off9[1:0];
  assign wr       = io_we && in_bank;
  assign rd       = io_re && !io_we && in_bank;

  logic [NB-1:0] data_q;
  logic [NB-1:0] ddr_q;
  logic [NB-1:0] s1_q;
  logic [NB-1:0] s2_q;

  assign pins_out = data_q;
  assign pins_oe  = ddr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ddr_q  <= '0;
    end else if (wr) begin
      for (int p = 0; p < NPORTS; p++) begin
        if (port_idx == 3'(p)) begin
          if (reg_idx == 2'd0) data_q[p*WIDTH +: WIDTH] <= io_wdata[WIDTH-1:0];
          if (reg_idx == 2'd1) ddr_q[p*WIDTH +: WIDTH]  <= io_wdata[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= pins_in;
      s2_q <= s1_q;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [NB-1:0] imask_q;
  logic [NB-1:0] iflag_q;
  logic [NB-1:0] prev_q;
  logic [NB-1:0] edge_hit;
  logic [NB-1:0] clr;
  logic [1:0]    arm_q;
  logic          armed;
  logic          irq_q;

  // Detection stays off until s1/s2/prev have all loaded real pin values after reset.
  assign armed = (arm_q == 2'd3);

  always_comb begin
    if (IRQ_EDGE == 1)      edge_hit = s2_q & ~prev_q;
    else if (IRQ_EDGE == 2) edge_hit = ~s2_q & prev_q;
    else                    edge_hit = s2_q ^ prev_q;
    if (!armed) edge_hit = '0;
  end

  always_comb begin
    clr = '0;
    if (wr && reg_idx == 2'd3) begin
      for (int p = 0; p < NPORTS; p++) begin
        if (port_idx == 3'(p)) clr[p*WIDTH +: WIDTH] = io_wdata[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imask_q <= '0;
      iflag_q <= '0;
      prev_q  <= '0;
      arm_q   <= 2'd0;
      irq_q   <= 1'b0;
    end else begin
      prev_q <= s2_q;
      if (!armed) arm_q <= arm_q + 2'd1;
      if (wr && reg_idx == 2'd2) begin
        for (int p = 0; p < NPORTS; p++) begin
          if (port_idx == 3'(p)) imask_q[p*WIDTH +: WIDTH] <= io_wdata[WIDTH-1:0];
        end
      end
      // A new edge in the same cycle as a W1C keeps the flag set.
      iflag_q <= (iflag_q & ~clr) | edge_hit;
      irq_q   <= |(iflag_q & imask_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  logic [7:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (port_idx == 3'(p)) begin
        case (reg_idx)
          2'd0: rd_mux[WIDTH-1:0] = (ddr_q[p*WIDTH +: WIDTH] & data_q[p*WIDTH +: WIDTH])
                                  | (~ddr_q[p*WIDTH +: WIDTH] & s2_q[p*WIDTH +: WIDTH]);
          2'd1: rd_mux[WIDTH-1:0] = ddr_q[p*WIDTH +: WIDTH];
`ifdef GPIO_IRQ_EN
          2'd2: rd_mux[WIDTH-1:0] = imask_q[p*WIDTH +: WIDTH];
          2'd3: rd_mux[WIDTH-1:0] = iflag_q[p*WIDTH +: WIDTH];
`endif
          default: rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_rdata  <= 8'h00;
      io_rvalid <= 1'b0;
    end else begin
      io_rvalid <= rd;
      if (rd) io_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_as2650_gpio_ports.sv
// Directed bench for as2650_gpio_ports (NPORTS=2, WIDTH=8, BASE_ADDR=0, IRQ_EDGE=1 rising).
// Interrupt checks are built only when GPIO_IRQ_EN is defined; otherwise the tied-off paths are checked.
module tb_as2650_gpio_ports;

  logic        clk;
  logic        rst_n;
  logic [7:0]  io_addr;
  logic [7:0]  io_wdata;
  logic        io_we;
  logic        io_re;
  logic [7:0]  io_rdata;
  logic        io_rvalid;
  logic [15:0] pins_in;
  logic [15:0] pins_out;
  logic [15:0] pins_oe;
  logic        irq;

  int checks = 0;
  int errors = 0;

  as2650_gpio_ports #(
    .NPORTS(2), .WIDTH(8), .BASE_ADDR(8'h00), .IRQ_EDGE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we), .io_re(io_re),
    .io_rdata(io_rdata), .io_rvalid(io_rvalid),
    .pins_in(pins_in), .pins_out(pins_out), .pins_oe(pins_oe),
    .irq(irq)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Driver tasks: strobes are set on a falling edge and sampled by the next rising edge.
  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    io_addr = a; io_wdata = d; io_we = 1'b1;
    @(negedge clk);
    io_we = 1'b0;
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [7:0] d, output logic v);
    @(negedge clk);
    io_addr = a; io_re = 1'b1;
    @(negedge clk);
    io_re = 1'b0;
    d = io_rdata;
    v = io_rvalid;
  endtask

  logic [7:0] rd_d;
  logic       rd_v;

  initial begin
    rst_n = 1'b0; io_addr = 8'h00; io_wdata = 8'h00; io_we = 1'b0; io_re = 1'b0;
    pins_in = 16'hFFFF;

    // Reset with pins held high
    cyc(3);
    check("rst_pins_out", pins_out, 16'h0000);
    check("rst_pins_oe", pins_oe, 16'h0000);
    check("rst_irq", irq, 1'b0);
    check("rst_rvalid", io_rvalid, 1'b0);
    check("rst_rdata", io_rdata, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    cyc(10);
    check("arm_irq", irq, 1'b0);
    rd_reg(8'h03, rd_d, rd_v);
    check("arm_iflag0", rd_d, 8'h00);
    check("arm_iflag0_v", rd_v, 1'b1);
    cyc(1);
    check("rvalid_pulse", io_rvalid, 1'b0);
    rd_reg(8'h07, rd_d, rd_v);
    check("arm_iflag1", rd_d, 8'h00);

    // Direction / data, port 0
    pins_in = 16'h0000;
    cyc(4);
    wr_reg(8'h01, 8'hF0);
    wr_reg(8'h00, 8'h55);
    check("ddr0_oe", pins_oe, 16'h00F0);
    check("data0_out", pins_out, 16'h0055);
    pins_in = 16'h00A3;
    cyc(2);
    rd_reg(8'h00, rd_d, rd_v);
    check("data0_rd", rd_d, 8'h53);
    check("data0_rd_v", rd_v, 1'b1);
    rd_reg(8'h01, rd_d, rd_v);
    check("ddr0_rd", rd_d, 8'hF0);
    rd_reg(8'h00, rd_d, rd_v);
    check("data0_rd2", rd_d, 8'h53);

    // Decode: out-of-bank write and reads
    wr_reg(8'h08, 8'hFF);
    check("oob_wr_out", pins_out, 16'h0055);
    check("oob_wr_oe", pins_oe, 16'h00F0);
    rd_reg(8'h08, rd_d, rd_v);
    check("oob_rd_v", rd_v, 1'b0);
    check("oob_rd_hold", rd_d, 8'h53);
    rd_reg(8'hFF, rd_d, rd_v);
    check("oob_rd_ff_v", rd_v, 1'b0);

    // Simultaneous write and read to DATA0
    @(negedge clk);
    io_addr = 8'h00; io_wdata = 8'hAA; io_we = 1'b1; io_re = 1'b1;
    @(negedge clk);
    io_we = 1'b0; io_re = 1'b0;
    check("wr_rd_out", pins_out, 16'h00AA);
    check("wr_rd_v", io_rvalid, 1'b0);
    check("wr_rd_hold", io_rdata, 8'h53);
    cyc(1);
    check("wr_rd_v2", io_rvalid, 1'b0);

    // Port 1 direction / data
    wr_reg(8'h05, 8'hFF);
    check("ddr1_oe", pins_oe, 16'hFFF0);
    wr_reg(8'h04, 8'h3C);
    check("data1_out", pins_out, 16'h3CAA);
    rd_reg(8'h04, rd_d, rd_v);
    check("data1_rd", rd_d, 8'h3C);
    wr_reg(8'h05, 8'h00);
    check("ddr1_oe_off", pins_oe, 16'h00F0);
    rd_reg(8'h04, rd_d, rd_v);
    check("data1_rd_in", rd_d, 8'h00);
    rd_reg(8'h00, rd_d, rd_v);
    check("data0_mixed", rd_d, 8'hA3);

`ifdef GPIO_IRQ_EN
    // Rising edges 00->A3 on port 0 were flagged
    rd_reg(8'h03, rd_d, rd_v);
    check("iflag0_set", rd_d, 8'hA3);
    wr_reg(8'h03, 8'hFF);
    rd_reg(8'h03, rd_d, rd_v);
    check("iflag0_clr", rd_d, 8'h00);
    check("irq_unmasked", irq, 1'b0);

    // Interrupt path on pin 8
    wr_reg(8'h07, 8'hFF);
    wr_reg(8'h06, 8'h01);
    rd_reg(8'h06, rd_d, rd_v);
    check("imask1_rd", rd_d, 8'h01);
    @(negedge clk); pins_in[8] = 1'b1;
    cyc(1);
    check("irq_k", irq, 1'b0);
    cyc(1);
    check("irq_k1", irq, 1'b0);
    pins_in[8] = 1'b0;
    cyc(1);
    check("irq_k2", irq, 1'b0);
    cyc(1);
    check("irq_k3", irq, 1'b1);
    rd_reg(8'h07, rd_d, rd_v);
    check("iflag1_set", rd_d, 8'h01);

    // Mask off then on
    wr_reg(8'h06, 8'h00);
    check("mask_off_w", irq, 1'b1);
    cyc(1);
    check("mask_off_w1", irq, 1'b0);
    wr_reg(8'h06, 8'h01);
    check("mask_on_w", irq, 1'b0);
    cyc(1);
    check("mask_on_w1", irq, 1'b1);

    // W1C drops irq one edge after the write edge
    wr_reg(8'h07, 8'h01);
    check("clr_w", irq, 1'b1);
    cyc(1);
    check("clr_w1", irq, 1'b0);

    // Re-arm a pending flag, then collide a W1C with a new rising edge
    @(negedge clk); pins_in[8] = 1'b1;
    cyc(4);
    check("pend_irq", irq, 1'b1);
    pins_in[8] = 1'b0;
    cyc(4);
    pins_in[8] = 1'b1;
    cyc(1);
    cyc(1);
    io_addr = 8'h07; io_wdata = 8'h01; io_we = 1'b1;
    cyc(1);
    io_we = 1'b0;
    check("coll_irq_w", irq, 1'b1);
    cyc(1);
    check("coll_irq_w1", irq, 1'b1);
    rd_reg(8'h07, rd_d, rd_v);
    check("coll_flag", rd_d, 8'h01);
    wr_reg(8'h07, 8'h01);
    cyc(1);
    check("coll_clr", irq, 1'b0);
    pins_in[8] = 1'b0;
    cyc(4);
`else
    // Interrupt logic absent: irq tied low, r2/r3 read zero
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); pins_in = ~pins_in;
      cyc(2);
      check("off_irq", irq, 1'b0);
    end
    wr_reg(8'h02, 8'hFF);
    wr_reg(8'h07, 8'hFF);
    rd_reg(8'h02, rd_d, rd_v);
    check("off_r2p0", rd_d, 8'h00);
    check("off_r2p0_v", rd_v, 1'b1);
    rd_reg(8'h03, rd_d, rd_v);
    check("off_r3p0", rd_d, 8'h00);
    rd_reg(8'h06, rd_d, rd_v);
    check("off_r2p1", rd_d, 8'h00);
    rd_reg(8'h07, rd_d, rd_v);
    check("off_r3p1", rd_d, 8'h00);
    check("off_oe_kept", pins_oe, 16'h00F0);
`endif

    // Reset asserted during a write drops the access
    @(negedge clk);
    io_addr = 8'h01; io_wdata = 8'h11; io_we = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    io_we = 1'b0;
    check("rst_mid_oe", pins_oe, 16'h0000);
    check("rst_mid_out", pins_out, 16'h0000);
    check("rst_mid_irq", irq, 1'b0);
    rst_n = 1'b1;
    cyc(2);
    check("rst_mid_oe2", pins_oe, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
